time_tmr_rr_arbiter: RTL and testbench



---
 rtl/time_tmr_arb_pkg.sv | 15 +
 rtl/time_tmr_rr_select.sv | 26 ++
 rtl/time_tmr_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_time_tmr_rr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/time_tmr_arb_pkg.sv
// Shared types and constants for the time-redundant round-robin arbiter.
package time_tmr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2,
      SEND2 = 2'd3
   } state_t;

   typedef logic [1:0] replica_t;

   localparam int NumReplicas = 3;

endpackage

// File: rtl/time_tmr_rr_select.sv
// Round-robin search: first valid requester at or above the pointer, wrapping.
module time_tmr_rr_select #(
   parameter int NumReq = 4,
   parameter int SrcW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] i_valid,
   input  logic [SrcW-1:0]   i_rr_ptr,
   output logic [SrcW-1:0]   o_sel,
   output logic              o_any_valid
);

   always_comb begin
      o_sel       = '0;
      o_any_valid = 1'b0;
      // Walk from the farthest offset down so the nearest valid one wins.
      for (int k = NumReq - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(i_rr_ptr) + k) % NumReq;
         if (i_valid[idx]) begin
            o_sel       = SrcW'(idx);
            o_any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_tmr_rr_arbiter.sv
// Round-robin arbiter that replays each granted transaction three times (or once).
// Optional completion counter enabled by defining TIME_TMR_ARB_PERF_EN.
module time_tmr_rr_arbiter
   import time_tmr_arb_pkg::*;
#(
   parameter int NumReq    = 4,
   parameter int DataWidth = 32,
   parameter int IDSize    = 2,
   parameter int SrcW      = $clog2(NumReq)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        enable_i,
   input  logic [NumReq*DataWidth-1:0] req_data_i,
   input  logic [NumReq-1:0]           req_valid_i,
   output logic [NumReq-1:0]           req_ready_o,
   output logic [DataWidth-1:0]        data_o,
   output logic [IDSize-1:0]           id_o,
   output logic [SrcW-1:0]             src_o,
   output logic [1:0]                  replica_o,
   output logic                        valid_o,
   input  logic                        ready_i
`ifdef TIME_TMR_ARB_PERF_EN
   ,
   input  logic                        clr_cnt_i,
   output logic [15:0]                 done_cnt_o
`endif
);

   state_t                r_state;
   state_t                w_state_next;
   logic [SrcW-1:0]       r_rr_ptr;
   logic [IDSize-1:0]     r_id;
   logic [DataWidth-1:0]  r_data;
   logic [SrcW-1:0]       r_src;
   logic                  r_en;

   logic [DataWidth-1:0]  w_req_data [NumReq];
   logic [SrcW-1:0]       w_sel;
   logic                  w_any_valid;
   logic                  w_final;
   logic                  w_capture;
   logic                  w_take;

   genvar gi;
   generate
      for (gi = 0; gi < NumReq; gi++) begin : g_slice
         assign w_req_data[gi] = req_data_i[gi*DataWidth +: DataWidth];
      end
   endgenerate

   time_tmr_rr_select #(
      .NumReq (NumReq),
      .SrcW   (SrcW)
   ) u_select (
      .i_valid     (req_valid_i),
      .i_rr_ptr    (r_rr_ptr),
      .o_sel       (w_sel),
      .o_any_valid (w_any_valid)
   );

   // Last beat of the current transaction; accepting it frees the slot for a new capture.
   assign w_final   = (r_state == SEND2) || ((r_state == SEND0) && !r_en);
   assign w_capture = (r_state == IDLE) || (w_final && ready_i);
   assign w_take    = w_capture && w_any_valid && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_rr_ptr <= '0;
         r_id     <= '0;
         r_data   <= '0;
         r_src    <= '0;
         r_en     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_take) begin
            r_data   <= w_req_data[w_sel];
            r_src    <= w_sel;
            r_en     <= enable_i;
            r_id     <= r_id + IDSize'(1);
            r_rr_ptr <= (w_sel == SrcW'(NumReq - 1)) ? '0 : w_sel + SrcW'(1);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_capture) begin
         w_state_next = w_any_valid ? SEND0 : IDLE;
      end else begin
         case (r_state)
            SEND0:   if (ready_i && r_en) w_state_next = SEND1;
            SEND1:   if (ready_i)         w_state_next = SEND2;
            default: w_state_next = r_state;
         endcase
      end
   end

   always_comb begin
      valid_o     = 1'b0;
      replica_o   = replica_t'(0);
      req_ready_o = '0;
      if (w_take) req_ready_o[w_sel] = 1'b1;
      case (r_state)
         SEND0: begin
            valid_o   = 1'b1;
            replica_o = replica_t'(0);
         end
         SEND1: begin
            valid_o   = 1'b1;
            replica_o = replica_t'(1);
         end
         SEND2: begin
            valid_o   = 1'b1;
            replica_o = replica_t'(NumReplicas - 1);
         end
         default: begin
            valid_o   = 1'b0;
            replica_o = replica_t'(0);
         end
      endcase
   end

   assign data_o = r_data;
   assign id_o   = r_id;
   assign src_o  = r_src;

`ifdef TIME_TMR_ARB_PERF_EN
   logic [15:0] r_done_cnt;

   // Clear wins over a coincident completion; count sticks at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_done_cnt <= '0;
      end else if (clr_cnt_i) begin
         r_done_cnt <= '0;
      end else if (w_final && ready_i && (r_done_cnt != 16'hFFFF)) begin
         r_done_cnt <= r_done_cnt + 16'd1;
      end
   end

   assign done_cnt_o = r_done_cnt;
`endif

endmodule

// File: tb/tb_time_tmr_rr_arbiter.sv
// Directed self-checking bench for time_tmr_rr_arbiter (4 requesters, 32-bit data, 2-bit ID).
module tb_time_tmr_rr_arbiter;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          enable_i;
   logic [127:0]  req_data_i;
   logic [3:0]    req_valid_i;
   logic [3:0]    req_ready_o;
   logic [31:0]   data_o;
   logic [1:0]    id_o;
   logic [1:0]    src_o;
   logic [1:0]    replica_o;
   logic          valid_o;
   logic          ready_i;
`ifdef TIME_TMR_ARB_PERF_EN
   logic          clr_cnt_i;
   logic [15:0]   done_cnt_o;
`endif

   int tests = 0;
   int fails = 0;

   time_tmr_rr_arbiter dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .req_data_i  (req_data_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .data_o      (data_o),
      .id_o        (id_o),
      .src_o       (src_o),
      .replica_o   (replica_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
`ifdef TIME_TMR_ARB_PERF_EN
      ,
      .clr_cnt_i   (clr_cnt_i),
      .done_cnt_o  (done_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int v, input int d, input int id,
                          input int src, input int rep, input int rr);
      check({tag, "_valid"},   32'(valid_o),     v);
      check({tag, "_data"},    data_o,           d);
      check({tag, "_id"},      32'(id_o),        id);
      check({tag, "_src"},     32'(src_o),       src);
      check({tag, "_replica"}, 32'(replica_o),   rep);
      check({tag, "_rdy"},     32'(req_ready_o), rr);
   endtask

   task automatic set_data(input int idx, input logic [31:0] val);
      req_data_i[idx*32 +: 32] = val;
   endtask

   initial begin
      rst_i       = 1'b1;
      enable_i    = 1'b0;
      req_valid_i = '0;
      req_data_i  = '0;
      ready_i     = 1'b1;
`ifdef TIME_TMR_ARB_PERF_EN
      clr_cnt_i   = 1'b0;
`endif
      tick();
      tick();
      #1 chk_out("reset", 0, 0, 0, 0, 0, 0);

      // Single requester, tripled
      rst_i = 1'b0;
      enable_i = 1'b1;
      req_valid_i = 4'b0001;
      set_data(0, 32'hA5);
      #1 check("t1_grant", 32'(req_ready_o), 1);
      tick();
      req_valid_i = '0;
      #1 chk_out("t1_b0", 1, 'hA5, 1, 0, 0, 0);
      tick();
      #1 chk_out("t1_b1", 1, 'hA5, 1, 0, 1, 0);
      tick();
      #1 chk_out("t1_b2", 1, 'hA5, 1, 0, 2, 0);
      tick();
      #1 check("t1_idle", 32'(valid_o), 0);

      // All requesters busy: rotation 0,1,2,3,0 with no gaps
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) set_data(i, 32'h10 + i);
      req_valid_i = 4'b1111;
      #1 check("t2_grant0", 32'(req_ready_o), 1);
      for (int t = 0; t < 5; t++) begin
         tick();
         for (int r = 0; r < 3; r++) begin
            #1 chk_out($sformatf("t2_tx%0d_r%0d", t, r), 1, 'h10 + (t % 4), (t + 1) % 4,
                       t % 4, r, (r == 2) ? (1 << ((t + 1) % 4)) : 0);
            if (r < 2) tick();
         end
      end
      req_valid_i = '0;
      tick();
      #1 check("t2_idle", 32'(valid_o), 0);

      // Back-pressure in SEND1
      req_valid_i = 4'b0100;
      set_data(2, 32'h22);
      #1 check("t3_grant", 32'(req_ready_o), 4);
      tick();
      req_valid_i = 4'b1111;
      #1 chk_out("t3_b0", 1, 'h22, 2, 2, 0, 0);
      tick();
      ready_i = 1'b0;
      #1 chk_out("t3_b1", 1, 'h22, 2, 2, 1, 0);
      for (int s = 0; s < 5; s++) begin
         tick();
         #1 chk_out($sformatf("t3_hold%0d", s), 1, 'h22, 2, 2, 1, 0);
      end
      ready_i = 1'b1;
      #1 check("t3_rel_rep", 32'(replica_o), 1);
      tick();
      #1 chk_out("t3_b2", 1, 'h22, 2, 2, 2, 8);
      req_valid_i = '0;
      tick();
      #1 check("t3_idle", 32'(valid_o), 0);

      // Redundancy off: single beat, immediate recapture; enable ignored mid-sequence
      enable_i = 1'b0;
      req_valid_i = 4'b0100;
      set_data(2, 32'h33);
      #1 check("t4_grant", 32'(req_ready_o), 4);
      tick();
      #1 chk_out("t4_single", 1, 'h33, 3, 2, 0, 4);
      set_data(2, 32'h44);
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      #1 chk_out("t4_b0", 1, 'h44, 0, 2, 0, 0);
      tick();
      enable_i = 1'b1;
      #1 chk_out("t4_b1", 1, 'h44, 0, 2, 1, 0);
      tick();
      #1 chk_out("t4_b2", 1, 'h44, 0, 2, 2, 4);
      req_valid_i = '0;
      tick();
      #1 check("t4_idle", 32'(valid_o), 0);

      // Reset in SEND1 abandons the triplet
      req_valid_i = 4'b0010;
      set_data(1, 32'h55);
      #1 check("t5_grant", 32'(req_ready_o), 2);
      tick();
      req_valid_i = '0;
      #1 chk_out("t5_b0", 1, 'h55, 1, 1, 0, 0);
      tick();
      #1 chk_out("t5_b1", 1, 'h55, 1, 1, 1, 0);
      rst_i = 1'b1;
      req_valid_i = 4'b1111;
      tick();
      #1 chk_out("t5_rst", 0, 0, 0, 0, 0, 0);
      rst_i = 1'b0;
      #1 check("t5_regrant", 32'(req_ready_o), 1);
      tick();
      req_valid_i = '0;
      #1 chk_out("t5_after", 1, 'h10, 1, 0, 0, 0);
      tick();
      tick();
      tick();
      #1 check("t5_idle", 32'(valid_o), 0);

`ifdef TIME_TMR_ARB_PERF_EN
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1 check("p_rst", 32'(done_cnt_o), 0);
      enable_i = 1'b1;
      req_valid_i = 4'b0001;
      for (int c = 0; c < 10; c++) tick();
      #1 check("p_three", 32'(done_cnt_o), 3);
      tick();
      tick();
      clr_cnt_i = 1'b1;
      #1 check("p_final_rep", 32'(replica_o), 2);
      tick();
      clr_cnt_i = 1'b0;
      req_valid_i = '0;
      #1 check("p_clr", 32'(done_cnt_o), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
